// File: rtl/ppe_rr_mask_stage_if.sv
// ----------------------------------------------------------------------------
// ppe_rr_mask_stage_if
// Purpose : Groups the request, encoder-output and grant-feedback handshakes
//           of the round-robin mask stage into one bundle.
// Signals :
//   req_valid/req_ready/req_vec          upstream request vector handshake
//   out_valid/out_ready                  registered vectors toward encoder
//   out_masked/out_raw                   masked (i < ptr) and raw vectors
//   out_masked_any/out_raw_any           OR-reductions of the two vectors
//   grant_valid/grant_idx                index granted by the encoder
// Modports:
//   master  upstream/encoder side (drives requests, out_ready, grants)
//   slave   the mask stage itself
// ----------------------------------------------------------------------------
interface ppe_rr_mask_stage_if #(
    parameter int unsigned N = 1024,
    parameter int unsigned W = 10
);
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_vec;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_masked;
    logic [N-1:0] out_raw;
    logic         out_masked_any;
    logic         out_raw_any;

    logic         grant_valid;
    logic [W-1:0] grant_idx;

    modport master (
        output req_valid, req_vec, out_ready, grant_valid, grant_idx,
        input  req_ready, out_valid, out_masked, out_raw,
               out_masked_any, out_raw_any
    );

    modport slave (
        input  req_valid, req_vec, out_ready, grant_valid, grant_idx,
        output req_ready, out_valid, out_masked, out_raw,
               out_masked_any, out_raw_any
    );
endinterface

// File: rtl/ppe_rr_mask_stage.sv
// ----------------------------------------------------------------------------
// ppe_rr_mask_stage
// Purpose : Registered front-end of the programmable priority encoder.
//           Captures a request vector, presents it raw and masked to the
//           indices strictly below the priority pointer, and moves the
//           pointer to each granted index so the highest-index-wins encoder
//           behaves round-robin.
// Ports   :
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   bus           slave modport of ppe_rr_mask_stage_if (request, output and
//                 grant handshakes)
//   ptr_load      in   software pointer load strobe (any state)
//   ptr_load_val  in   value loaded into the pointer
//   ptr           out  current priority pointer
// ----------------------------------------------------------------------------
module ppe_rr_mask_stage #(
    parameter int unsigned N = 1024,
    parameter int unsigned W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ppe_rr_mask_stage_if.slave    bus,
    input  logic                  ptr_load,
    input  logic [W-1:0]          ptr_load_val,
    output logic [W-1:0]          ptr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_ptr;
    logic         r_out_valid;
    logic [N-1:0] r_masked;
    logic [N-1:0] r_raw;
    logic         r_masked_any;
    logic         r_raw_any;

    logic [N-1:0] w_mask;
    logic [N-1:0] w_masked_next;

    // Bits strictly below the pointer: ptr = 0 yields an all-zero mask.
    assign w_mask        = ~({N{1'b1}} << r_ptr);
    assign w_masked_next = bus.req_vec & w_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_out_valid  <= 1'b0;
            r_masked     <= '0;
            r_raw        <= '0;
            r_masked_any <= 1'b0;
            r_raw_any    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_raw        <= bus.req_vec;
                        r_masked     <= w_masked_next;
                        r_raw_any    <= |bus.req_vec;
                        r_masked_any <= |w_masked_next;
                        r_out_valid  <= 1'b1;
                        r_state      <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        // An empty request produces no grant, so skip WAIT.
                        r_state     <= r_raw_any ? WAIT : IDLE;
                    end
                end
                WAIT: begin
                    if (bus.grant_valid) begin
                        r_ptr   <= bus.grant_idx;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Software load overrides a same-cycle grant update.
            if (ptr_load) begin
                r_ptr <= ptr_load_val;
            end
        end
    end

    assign bus.req_ready      = (r_state == IDLE);
    assign bus.out_valid      = r_out_valid;
    assign bus.out_masked     = r_masked;
    assign bus.out_raw        = r_raw;
    assign bus.out_masked_any = r_masked_any;
    assign bus.out_raw_any    = r_raw_any;
    assign ptr                = r_ptr;

endmodule

// File: tb/tb_ppe_rr_mask_stage.sv
// ----------------------------------------------------------------------------
// tb_ppe_rr_mask_stage
// Directed bench for ppe_rr_mask_stage with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_ppe_rr_mask_stage;

    localparam int unsigned N = 1024;
    localparam int unsigned W = 10;

    logic         clk;
    logic         rst_n;
    logic         ptr_load;
    logic [W-1:0] ptr_load_val;
    logic [W-1:0] ptr;

    int n_cmp;
    int n_err;

    ppe_rr_mask_stage_if #(.N(N), .W(W)) bus ();

    ppe_rr_mask_stage #(.N(N), .W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .ptr_load     (ptr_load),
        .ptr_load_val (ptr_load_val),
        .ptr          (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got,
                         input logic [N-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] bit_of(input int unsigned i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents vec for one accept edge; afterwards the stage is in OUT.
    task automatic capture(input logic [N-1:0] vec);
        bus.req_valid = 1'b1;
        bus.req_vec   = vec;
        tick();
        bus.req_valid = 1'b0;
        bus.req_vec   = '1;
    endtask

    task automatic grant(input logic [W-1:0] idx);
        bus.grant_valid = 1'b1;
        bus.grant_idx   = idx;
        tick();
        bus.grant_valid = 1'b0;
    endtask

    logic [N-1:0] v;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_vec     = '0;
        bus.out_ready   = 1'b0;
        bus.grant_valid = 1'b0;
        bus.grant_idx   = '0;
        ptr_load        = 1'b0;
        ptr_load_val    = '0;

        #12;
        check("rst_out_valid", N'(bus.out_valid), N'(0));
        check("rst_req_ready", N'(bus.req_ready), N'(1));
        check("rst_ptr",       N'(ptr),           N'(0));
        check("rst_raw",       bus.out_raw,       '0);
        check("rst_masked",    bus.out_masked,    '0);
        check("rst_raw_any",   N'(bus.out_raw_any), N'(0));
        rst_n = 1'b1;
        #5;
        tick();

        // 1: ptr = 0 -> masked empty, wrap to raw
        bus.out_ready = 1'b1;
        v = bit_of(5) | bit_of(700);
        capture(v);
        check("t1_out_valid",  N'(bus.out_valid),      N'(1));
        check("t1_raw",        bus.out_raw,            v);
        check("t1_masked",     bus.out_masked,         '0);
        check("t1_masked_any", N'(bus.out_masked_any), N'(0));
        check("t1_raw_any",    N'(bus.out_raw_any),    N'(1));
        tick();
        check("t1_wait_valid", N'(bus.out_valid), N'(0));
        check("t1_wait_ready", N'(bus.req_ready), N'(0));
        grant(10'd700);
        check("t1_ptr",        N'(ptr),           N'(700));
        check("t1_idle_ready", N'(bus.req_ready), N'(1));

        // 2: ptr = 700 keeps only bit 5
        v = bit_of(5) | bit_of(700) | bit_of(900);
        capture(v);
        check("t2_masked",     bus.out_masked,         bit_of(5));
        check("t2_masked_any", N'(bus.out_masked_any), N'(1));
        tick();
        grant(10'd5);
        check("t2_ptr", N'(ptr), N'(5));

        // 3: strict less-than, then wrap case
        capture(bit_of(3) | bit_of(5));
        check("t3_masked", bus.out_masked, bit_of(3));
        tick();
        grant(10'd5);
        check("t3_ptr", N'(ptr), N'(5));
        capture(bit_of(5));
        check("t3_wrap_masked",     bus.out_masked,         '0);
        check("t3_wrap_masked_any", N'(bus.out_masked_any), N'(0));
        check("t3_wrap_raw_any",    N'(bus.out_raw_any),    N'(1));
        tick();
        grant(10'd5);

        // 4: backpressure holds outputs, ignores new requests
        bus.out_ready = 1'b0;
        v = bit_of(1) | bit_of(9);
        capture(v);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                bus.req_valid = 1'b1;
                bus.req_vec   = bit_of(2);
            end else begin
                bus.req_valid = 1'b0;
            end
            tick();
            check("t4_valid",  N'(bus.out_valid), N'(1));
            check("t4_ready",  N'(bus.req_ready), N'(0));
            check("t4_raw",    bus.out_raw,       v);
            check("t4_masked", bus.out_masked,    bit_of(1));
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("t4_drop_valid", N'(bus.out_valid), N'(0));
        grant(10'd9);
        check("t4_ptr", N'(ptr), N'(9));

        // 5: empty request returns straight to IDLE; grant ignored in IDLE
        capture('0);
        check("t5_raw_any", N'(bus.out_raw_any), N'(0));
        check("t5_valid",   N'(bus.out_valid),   N'(1));
        tick();
        check("t5_idle_ready", N'(bus.req_ready), N'(1));
        check("t5_idle_valid", N'(bus.out_valid), N'(0));
        grant(10'd33);
        check("t5_ptr", N'(ptr), N'(9));

        // 6: load beats grant in WAIT; async reset mid-OUT
        capture(bit_of(50));
        check("t6_masked", bus.out_masked, '0);
        tick();
        ptr_load     = 1'b1;
        ptr_load_val = 10'd100;
        grant(10'd40);
        ptr_load = 1'b0;
        check("t6_ptr",   N'(ptr),           N'(100));
        check("t6_ready", N'(bus.req_ready), N'(1));
        bus.out_ready = 1'b0;
        v = bit_of(60) | bit_of(200);
        capture(v);
        check("t6_newptr_masked", bus.out_masked, bit_of(60));
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_arst_valid", N'(bus.out_valid), N'(0));
        check("t6_arst_ptr",   N'(ptr),           N'(0));
        check("t6_arst_ready", N'(bus.req_ready), N'(1));
        check("t6_arst_raw",   bus.out_raw,       '0);
        #10;
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ppe_rr_mask_stage.md
Name: ppe_rr_mask_stage

Overview:
- Registered front-end stage that feeds the 1024-to-10 priority encoder in the programmable priority encoder datapath.
- Captures a request vector and holds a programmable priority pointer.
- Emits two vectors to the encoder:
  - a masked vector, containing only the requests below the pointer;
  - the raw vector, used when the masked vector is empty (wrap).
- Takes the granted index back from the encoder and advances the pointer, giving round-robin fairness on top of the fixed highest-index-wins encoder.

Parameters:
- N, 1024, request vector width.
- W, 10, index/pointer width (must satisfy 2^W >= N).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  upstream request vector valid.
- req_ready  out  1  stage can accept a request vector.
- req_vec  in  N  request bits; bit i = requester i.
- out_valid  out  1  registered vectors valid toward the encoder.
- out_ready  in  1  encoder side accepts the vectors.
- out_masked  out  N  req_vec & mask, where mask[i] = (i < ptr).
- out_raw  out  N  captured req_vec, unmodified.
- out_masked_any  out  1  OR-reduce of out_masked.
- out_raw_any  out  1  OR-reduce of out_raw.
- grant_valid  in  1  encoder result valid (feedback).
- grant_idx  in  W  encoder result index.
- ptr_load  in  1  software pointer load strobe.
- ptr_load_val  in  W  value loaded into ptr.
- ptr  out  W  current priority pointer.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values (rst_n low, asynchronous):
  - state = IDLE;
  - ptr = 0;
  - out_valid = 0;
  - out_masked = 0, out_raw = 0, out_masked_any = 0, out_raw_any = 0.
  - req_ready follows the state, so it reads 1 during and after reset.
- States: IDLE, OUT, WAIT.
- IDLE:
  - req_ready = 1.
  - On req_valid, at the edge:
    - out_raw <= req_vec;
    - out_masked <= req_vec & mask(ptr current at that edge);
    - both any flags are registered from the same values;
    - go to OUT.
- OUT:
  - out_valid = 1, req_ready = 0.
  - Outputs are held stable until out_ready is seen.
  - On out_ready:
    - if out_raw_any = 1, go to WAIT;
    - if out_raw_any = 0, go to IDLE (no grant is expected).
  - out_valid drops in the cycle after the handshake.
- WAIT:
  - out_valid = 0, req_ready = 0.
  - On grant_valid: ptr <= grant_idx, go to IDLE.
- Grant feedback:
  - grant_valid is ignored in IDLE and OUT.
  - grant_idx is not range-checked.
- Pointer semantics:
  - The encoder selects the highest set index.
  - Masking to i < ptr selects the highest request strictly below the last grant.
  - An empty masked vector means wrap: the encoder side uses out_raw.
  - ptr = 0 makes out_masked all-zero.
- ptr_load:
  - Accepted in any state; ptr <= ptr_load_val at the edge.
  - Has priority over a simultaneous grant_valid in WAIT. The FSM still returns to IDLE.
  - A load while in OUT does not recompute the already-registered out_masked. The new ptr applies to the next capture.
- Latency and throughput:
  - Accept at edge k -> out_valid high from k+1.
  - Minimum 3 cycles per request (accept, out handshake, grant).
- Reset mid-operation: returns to IDLE immediately and clears all registered outputs and ptr. Any in-flight vector is dropped.
- req_vec is sampled only on the IDLE accept edge. Changes at other times have no effect.

Test Plan:
1. After reset, req_vec = bits {5,700}, out_ready = 1:
   - out_masked = 0, out_masked_any = 0, out_raw_any = 1;
   - FSM reaches WAIT;
   - grant_idx = 700 with grant_valid -> ptr = 700, req_ready = 1 next cycle.
2. With ptr = 700, req_vec = {5,700,900}:
   - out_masked = {5}, out_masked_any = 1;
   - grant_idx = 5 -> ptr = 5.
3. With ptr = 5, req_vec = {3,5}:
   - out_masked = {3} (bit 5 excluded, strict less-than).
   - Then req_vec = {5} -> out_masked_any = 0, out_raw_any = 1 (wrap case).
4. Backpressure: hold out_ready = 0 for 4 cycles while in OUT.
   - out_valid, out_masked and out_raw stay constant; req_ready = 0 throughout.
   - A req_valid pulse during this time is not captured.
5. req_vec = all zeros:
   - out_raw_any = 0;
   - after the out handshake, FSM returns to IDLE without waiting for a grant;
   - ptr is unchanged.
6. In WAIT, assert ptr_load = 1 (ptr_load_val = 100) together with grant_valid (grant_idx = 40):
   - ptr = 100, FSM returns to IDLE.
   - Then assert rst_n = 0 while in OUT: out_valid = 0, ptr = 0 and state = IDLE immediately, without waiting for a clock edge.
